game_ctrl: RTL and testbench
============================

# game_ctrl

Turn-sequencing control FSM for the Chicken Cha-Cha-Cha board. It sits on the opposite side of the `data_path` handshake. It turns the player buttons into flip/check requests, consumes the `go`, `C` and `W` results, and drives `statecombo_next_turn`, the move and steal strobes, and the current-player index `T`. It owns all game sequencing; `data_path` owns positions and comparisons.

## Interface
- `TIMEOUT_CYCLES`, default 250_000_000: idle cycles in FLIP_WAIT before the turn is forfeited. Minimum 2.
- `CNT_W`, default $clog2(TIMEOUT_CYCLES+1): width of the timeout counter.
- `clk` in 1: single clock; every flop is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: start button, level, already synchronised.
- `flip` in 1: card-flip button, level, already synchronised.
- `N` in 2: player count minus 1. 0 is coerced to 1.
- `go` in 1: datapath result, flipped card matches the next tile. Valid the cycle after `check_req`.
- `C` in 1: datapath result, the move landed on an opponent's tail. Valid the cycle after `move`.
- `W` in 1: datapath win flag. Valid the cycle after `move`.
- `check_req` out 1: one-cycle request to compare the flipped card.
- `move` out 1: one-cycle strobe to advance player `T` one tile.
- `steal` out 1: one-cycle strobe to transfer an opponent tail to `T`.
- `statecombo_next_turn` out 1: one-cycle strobe, the turn passes.
- `T` out 2: current player.
- `game_over` out 1: high while in WIN.
- `winner` out 2: winning player, held in WIN.

## Operation
- `start` and `flip` are rising-edge detected internally with one register each. Reset clears both registers to 1, so a button already held at reset does not fire.
- `N` is latched as `n_q` on the accepted start edge. A later change to `N` mid-game is ignored.

States:
- IDLE: wait for a `start` edge, then set T=0, latch `n_q`, go to FLIP_WAIT.
- FLIP_WAIT: the timeout counter increments every cycle.
  - A `flip` edge asserts `check_req` and goes to EVAL.
  - When the counter reaches TIMEOUT_CYCLES-1 with no flip, assert `statecombo_next_turn`, advance T, stay in FLIP_WAIT.
  - If a flip edge and the timeout occur in the same cycle, the flip wins.
- EVAL: sample `go`.
  - `go`=1: assert `move` and go to SETTLE.
  - `go`=0: assert `statecombo_next_turn`, advance T, go to FLIP_WAIT.
- SETTLE: sample `W` and `C`.
  - `W`=1: go to WIN with winner=T. `W` has priority over `C`.
  - Else `C`=1: assert `steal`, go to FLIP_WAIT; the same player continues.
  - Else go to FLIP_WAIT; the same player continues.
- WIN: `game_over`=1. Outputs are frozen. A `start` edge returns to IDLE with T=0, `winner` and `game_over` cleared.

Rules:
- T advance: T <= (T == n_q) ? 0 : T+1. Two-bit wrap, so at most 4 players.
- The timeout counter clears on every FLIP_WAIT entry and on every timeout.
- `start` edges are ignored outside IDLE and WIN.
- `flip` edges are ignored outside FLIP_WAIT.
- At most one of `check_req`, `move`, `steal`, `statecombo_next_turn` is high in any cycle.

## Timing
- Reset values: state=IDLE, T=0, winner=0, game_over=0, all strobes 0, counter 0.
- Reset mid-game aborts immediately to these values, asynchronously.
- All outputs are registered.
- Strobes are one cycle wide and are asserted in the cycle the FSM leaves the issuing state.
- Latency:
  - `flip` edge (registered sample) to `check_req`: 1 cycle.
  - `check_req` to decision on `go`: 1 cycle.
  - `move` to decision on `W`/`C`: 1 cycle.
- Minimum flip-to-next-flip acceptance: 3 cycles on the success path.
- Timeout fires exactly TIMEOUT_CYCLES cycles after FLIP_WAIT entry.

## Structure
- Shared package `game_pkg` holds:
  - the state encoding (IDLE, FLIP_WAIT, EVAL, SETTLE, WIN, 3-bit);
  - PLAYER_W=2;
  - the player-advance function.
- `data_path`'s next-turn logic reuses the player-advance function from `game_pkg`.
- One natural sub-module: `edge_det`, a rising-edge detector with reset-high state, instantiated for `start` and `flip`.

## Test plan
- Reset, then start edge with N=2, then flip edge, `go`=0 → `check_req` one cycle later, then one `statecombo_next_turn` pulse, T 0→1.
- N=2, three consecutive failed flips → T sequence 0→1→2→0.
- N=0 → treated as 2 players, T toggles 0↔1.
- TIMEOUT_CYCLES=8, no flip → pass pulse on the 8th FLIP_WAIT cycle, T advances. Flip edge coinciding with the timeout → `check_req` fires and no pass pulse.
- `go`=1 then `C`=1 → `move` pulse, then `steal` pulse, T unchanged.
  - `go`=1 with `W`=1 and `C`=1 together → WIN, winner=T, `game_over`=1, no `steal` pulse.
  - Then a start edge → IDLE with all outputs 0.
- Assert `rst` in SETTLE → all outputs 0 within the same cycle, FSM in IDLE. Flip edges afterwards are ignored until a start edge.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the Chicken Cha-Cha-Cha turn sequencer and its datapath:
// FSM state encoding, player index width and the player-advance rule.
package game_pkg;

  localparam int PLAYER_W = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FLIP_WAIT = 3'd1,
    S_EVAL      = 3'd2,
    S_SETTLE    = 3'd3,
    S_WIN       = 3'd4
  } state_t;

  // Next player after t, wrapping after the last player index.
  function automatic logic [PLAYER_W-1:0] player_advance(
    input logic [PLAYER_W-1:0] t,
    input logic [PLAYER_W-1:0] last
  );
    return (t == last) ? '0 : PLAYER_W'(t + 1'b1);
  endfunction

  // A single-player game makes no sense, so N=0 is played as two players.
  function automatic logic [PLAYER_W-1:0] coerce_last(input logic [PLAYER_W-1:0] n);
    return (n == '0) ? PLAYER_W'(1) : n;
  endfunction

endpackage

// File: rtl/game_ctrl_edge_det.sv
// Rising-edge detector; history resets high so a button held through reset never fires.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_d;
    end
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/game_ctrl.sv
// Turn-sequencing FSM: converts button edges into flip/check requests, consumes the
// datapath go/C/W results and drives the move, steal and turn-pass strobes.
module game_ctrl
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                flip,
  input  logic [PLAYER_W-1:0] N,
  input  logic                go,
  input  logic                C,
  input  logic                W,
  output logic                check_req,
  output logic                move,
  output logic                steal,
  output logic                statecombo_next_turn,
  output logic [PLAYER_W-1:0] T,
  output logic                game_over,
  output logic [PLAYER_W-1:0] winner
);

  state_t              r_state;
  logic [PLAYER_W-1:0] r_t;
  logic [PLAYER_W-1:0] r_last;
  logic [PLAYER_W-1:0] r_winner;
  logic                r_game_over;
  logic                r_check_req;
  logic                r_move;
  logic                r_steal;
  logic                r_pass;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_next;
  logic [PLAYER_W-1:0] w_t_next;
  logic [PLAYER_W-1:0] w_last_next;
  logic [PLAYER_W-1:0] w_winner_next;
  logic                w_game_over_next;
  logic                w_check_req_next;
  logic                w_move_next;
  logic                w_steal_next;
  logic                w_pass_next;
  logic [CNT_W-1:0]    w_cnt_next;
  logic                w_start_rise;
  logic                w_flip_rise;
  logic                w_timeout;

  edge_det u_start_edge (.clk(clk), .rst(rst), .i_d(start), .o_rise(w_start_rise));
  edge_det u_flip_edge  (.clk(clk), .rst(rst), .i_d(flip),  .o_rise(w_flip_rise));

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_next     = r_state;
    w_t_next         = r_t;
    w_last_next      = r_last;
    w_winner_next    = r_winner;
    w_game_over_next = r_game_over;
    w_check_req_next = 1'b0;
    w_move_next      = 1'b0;
    w_steal_next     = 1'b0;
    w_pass_next      = 1'b0;
    w_cnt_next       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start_rise) begin
          w_state_next = S_FLIP_WAIT;
          w_t_next     = '0;
          w_last_next  = coerce_last(N);
          w_cnt_next   = '0;
        end
      end
      S_FLIP_WAIT: begin
        // A flip landing on the timeout cycle still counts as a flip.
        if (w_flip_rise) begin
          w_check_req_next = 1'b1;
          w_state_next     = S_EVAL;
          w_cnt_next       = '0;
        end else if (w_timeout) begin
          w_pass_next = 1'b1;
          w_t_next    = player_advance(r_t, r_last);
          w_cnt_next  = '0;
        end else begin
          w_cnt_next = CNT_W'(r_cnt + 1'b1);
        end
      end
      S_EVAL: begin
        if (go) begin
          w_move_next  = 1'b1;
          w_state_next = S_SETTLE;
        end else begin
          w_pass_next  = 1'b1;
          w_t_next     = player_advance(r_t, r_last);
          w_state_next = S_FLIP_WAIT;
          w_cnt_next   = '0;
        end
      end
      S_SETTLE: begin
        w_cnt_next = '0;
        if (W) begin
          w_state_next     = S_WIN;
          w_winner_next    = r_t;
          w_game_over_next = 1'b1;
        end else begin
          w_steal_next = C;
          w_state_next = S_FLIP_WAIT;
        end
      end
      S_WIN: begin
        if (w_start_rise) begin
          w_state_next     = S_IDLE;
          w_t_next         = '0;
          w_winner_next    = '0;
          w_game_over_next = 1'b0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_t         <= '0;
      r_last      <= PLAYER_W'(1);
      r_winner    <= '0;
      r_game_over <= 1'b0;
      r_check_req <= 1'b0;
      r_move      <= 1'b0;
      r_steal     <= 1'b0;
      r_pass      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_t         <= w_t_next;
      r_last      <= w_last_next;
      r_winner    <= w_winner_next;
      r_game_over <= w_game_over_next;
      r_check_req <= w_check_req_next;
      r_move      <= w_move_next;
      r_steal     <= w_steal_next;
      r_pass      <= w_pass_next;
      r_cnt       <= w_cnt_next;
    end
  end

  assign check_req            = r_check_req;
  assign move                 = r_move;
  assign steal                = r_steal;
  assign statecombo_next_turn = r_pass;
  assign T                    = r_t;
  assign game_over            = r_game_over;
  assign winner               = r_winner;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: turn-level reference model (player index arithmetic,
// expected strobe per phase) driven by directed and randomized turns.
module tb_game_ctrl;

  localparam int TB_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       flip;
  logic [1:0] N;
  logic       go;
  logic       C;
  logic       W;
  logic       check_req;
  logic       move;
  logic       steal;
  logic       statecombo_next_turn;
  logic [1:0] T;
  logic       game_over;
  logic [1:0] winner;

  int checks = 0;
  int errors = 0;

  // Reference model state: whose turn it is, last player index, game result.
  logic [1:0] exp_t;
  logic [1:0] exp_last;
  logic [1:0] exp_winner;
  logic       exp_over;

  game_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .flip(flip), .N(N),
    .go(go), .C(C), .W(W),
    .check_req(check_req), .move(move), .steal(steal),
    .statecombo_next_turn(statecombo_next_turn),
    .T(T), .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [1:0] next_of(input logic [1:0] t, input logic [1:0] last);
    return 2'((int'(t) + 1) % (int'(last) + 1));
  endfunction

  task automatic test_start(input logic [1:0] n);
    logic [7:0] got;
    start = 1'b0;
    @(negedge clk);
    N = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_last   = (n == 2'd0) ? 2'd1 : n;
    exp_t      = 2'd0;
    exp_winner = 2'd0;
    exp_over   = 1'b0;
    got = {check_req, move, steal, statecombo_next_turn, T, game_over, 1'b0};
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL start_outputs got=%b want=%b", got, 8'h00);
    end
    $display("start N=%0d players=%0d", n, exp_last + 1);
  endtask

  // One flip: check_req, then move or pass, then steal / win / nothing.
  task automatic do_turn(input logic g, input logic c, input logic w, input int gap);
    logic [3:0] sv;
    logic [3:0] want;
    logic [4:0] st;
    logic [1:0] t_before;
    for (int k = 0; k < gap; k++) @(negedge clk);
    t_before = exp_t;
    go = g; C = c; W = w; flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    sv = {check_req, move, steal, statecombo_next_turn};
    checks++;
    if (sv !== 4'b1000) begin
      errors++;
      $display("FAIL flip_strobes got=%b want=1000", sv);
    end
    @(negedge clk);
    if (!g) begin
      exp_t = next_of(exp_t, exp_last);
      want = 4'b0001;
    end else begin
      want = 4'b0100;
    end
    sv = {check_req, move, steal, statecombo_next_turn};
    checks++;
    if (sv !== want || T !== exp_t) begin
      errors++;
      $display("FAIL eval_result strobes=%b T=%0d want strobes=%b T=%0d", sv, T, want, exp_t);
    end
    if (g) begin
      @(negedge clk);
      if (w) begin
        exp_over   = 1'b1;
        exp_winner = exp_t;
        want = 4'b0000;
      end else if (c) begin
        want = 4'b0010;
      end else begin
        want = 4'b0000;
      end
      sv = {check_req, move, steal, statecombo_next_turn};
      st = {T, winner, game_over};
      checks++;
      if (sv !== want || st !== {exp_t, exp_winner, exp_over}) begin
        errors++;
        $display("FAIL settle_result strobes=%b T/win/over=%b want strobes=%b T/win/over=%b",
                 sv, st, want, {exp_t, exp_winner, exp_over});
      end
    end
    go = 1'b0; C = 1'b0; W = 1'b0;
    $display("turn T=%0d go=%0d C=%0d W=%0d -> T=%0d over=%0d", t_before, g, c, w, exp_t, exp_over);
  endtask

  task automatic test_reset;
    logic [8:0] got;
    rst = 1'b1; start = 1'b1; flip = 1'b0; N = 2'd2; go = 1'b0; C = 1'b0; W = 1'b0;
    exp_t = 2'd0; exp_last = 2'd1; exp_winner = 2'd0; exp_over = 1'b0;
    repeat (2) @(negedge clk);
    got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
    checks++;
    if (got !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=%b", got, 9'd0);
    end
    rst = 1'b0;
    // start held through reset must not register as an edge
    repeat (2) @(negedge clk);
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
    checks++;
    if (got !== 9'd0) begin
      errors++;
      $display("FAIL held_start_ignored got=%b want=%b", got, 9'd0);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_pass_turn;
    test_start(2'd2);
    do_turn(1'b0, 1'b0, 1'b0, 1);
    checks++;
    if (T !== 2'd1) begin
      errors++;
      $display("FAIL first_pass T=%0d want=1", T);
    end
  endtask

  task automatic test_wrap;
    do_turn(1'b0, 1'b0, 1'b0, 0);
    do_turn(1'b0, 1'b0, 1'b0, 2);
    checks++;
    if (T !== 2'd0) begin
      errors++;
      $display("FAIL wrap_three_players T=%0d want=0", T);
    end
  endtask

  task automatic test_timeout;
    logic [3:0] sv;
    do_turn(1'b0, 1'b0, 1'b0, 0);
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      @(negedge clk);
      if (k == TB_TIMEOUT) exp_t = next_of(exp_t, exp_last);
      checks++;
      if (statecombo_next_turn !== (k == TB_TIMEOUT) || T !== exp_t) begin
        errors++;
        $display("FAIL timeout_cycle%0d pass=%0d T=%0d want pass=%0d T=%0d",
                 k, statecombo_next_turn, T, (k == TB_TIMEOUT), exp_t);
      end
    end
    $display("timeout fired -> T=%0d", exp_t);
    // flip edge lands on the cycle the next timeout would fire
    for (int k = 1; k < TB_TIMEOUT; k++) @(negedge clk);
    go = 1'b0;
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    sv = {check_req, move, steal, statecombo_next_turn};
    checks++;
    if (sv !== 4'b1000 || T !== exp_t) begin
      errors++;
      $display("FAIL flip_beats_timeout strobes=%b T=%0d want strobes=1000 T=%0d", sv, T, exp_t);
    end
    @(negedge clk);
    exp_t = next_of(exp_t, exp_last);
    sv = {check_req, move, steal, statecombo_next_turn};
    checks++;
    if (sv !== 4'b0001 || T !== exp_t) begin
      errors++;
      $display("FAIL after_coincide strobes=%b T=%0d want strobes=0001 T=%0d", sv, T, exp_t);
    end
    $display("flip on timeout cycle -> T=%0d", exp_t);
  endtask

  task automatic test_move_steal;
    do_turn(1'b1, 1'b1, 1'b0, 1);
    do_turn(1'b1, 1'b0, 1'b0, 0);
  endtask

  task automatic test_win_restart;
    logic [8:0] got;
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    repeat (2) @(negedge clk);
    got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
    checks++;
    if (got !== {4'b0000, exp_t, exp_winner, 1'b1}) begin
      errors++;
      $display("FAIL win_frozen got=%b want=%b", got, {4'b0000, exp_t, exp_winner, 1'b1});
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_t = 2'd0; exp_winner = 2'd0; exp_over = 1'b0;
    got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
    checks++;
    if (got !== 9'd0) begin
      errors++;
      $display("FAIL win_to_idle got=%b want=%b", got, 9'd0);
    end
    $display("restart from WIN -> idle");
  endtask

  task automatic test_win;
    do_turn(1'b0, 1'b0, 1'b0, 0);
    do_turn(1'b1, 1'b1, 1'b1, 1);
    test_win_restart();
  endtask

  task automatic test_n0;
    test_start(2'd0);
    for (int i = 0; i < 3; i++) do_turn(1'b0, 1'b0, 1'b0, i);
    checks++;
    if (T !== 2'd1) begin
      errors++;
      $display("FAIL two_player_toggle T=%0d want=1", T);
    end
  endtask

  task automatic test_reset_mid;
    logic [8:0] got;
    go = 1'b1; C = 1'b1; W = 1'b0; flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    @(negedge clk);
    checks++;
    if (move !== 1'b1) begin
      errors++;
      $display("FAIL premove move=%0d want=1", move);
    end
    rst = 1'b1;
    #1;
    got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
    checks++;
    if (got !== 9'd0) begin
      errors++;
      $display("FAIL async_reset got=%b want=%b", got, 9'd0);
    end
    @(negedge clk);
    rst = 1'b0; go = 1'b0; C = 1'b0;
    exp_t = 2'd0; exp_winner = 2'd0; exp_over = 1'b0;
    @(negedge clk);
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      got = {check_req, move, steal, statecombo_next_turn, T, winner, game_over};
      checks++;
      if (got !== 9'd0) begin
        errors++;
        $display("FAIL flip_in_idle cycle%0d got=%b want=%b", k, got, 9'd0);
      end
    end
    $display("mid-game reset -> idle");
  endtask

  task automatic test_random;
    logic g, c, w;
    test_start(2'($urandom_range(0, 3)));
    for (int i = 0; i < 40; i++) begin
      g = ($urandom_range(0, 2) != 0);
      c = 1'($urandom_range(0, 1));
      w = ($urandom_range(0, 5) == 0);
      N = 2'($urandom_range(0, 3));
      do_turn(g, c, w, int'($urandom_range(0, 3)));
      if (exp_over) begin
        test_win_restart();
        test_start(2'($urandom_range(0, 3)));
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass_turn();
    test_wrap();
    test_timeout();
    test_move_steal();
    test_win();
    test_n0();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
